hv_bist_ctrl: RTL
=================

# hv_bist_ctrl

HV-side BIST sequencer and scan-register arbiter. It starts a logic-BIST run on a power-on or software request and drives the enable of the HV logic-BIST checker. It captures the OWT and scan results, retries failed runs up to a programmable count, and reports a final pass/fail. It also shares the single scan-register engine between the BIST checker and the functional scan requester, so BIST traffic has exclusive access while BIST is enabled.

## Interface
Parameters:
- BIST_RETRY_NUM, 2, extra attempts allowed after a failed run (0..7).
- BIST_GAP_TH, 16, idle cycles with enable low between attempts (≥2).
- BIST_WDG_TH, 4096, RUN-state cycles allowed before watchdog fail; must exceed the checker timeout.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; i_rst_n, asynchronous, active-low; clock i_clk.
- i_por_bist_req  in  1  power-on BIST request pulse.
- i_sw_bist_req  in  1  software BIST request pulse.
- i_bist_abort  in  1  level; forces sequence exit.
- o_bist_en  out  1  enable to the BIST checker.
- i_hv_bist_done  in  1  checker done level.
- i_hv_owt_bist_rult  in  1  checker OWT fail flag.
- i_hv_scan_bist_rult  in  1  checker scan fail flag.
- o_bist_busy  out  1  sequence active (state ≠ IDLE).
- o_bist_cmplt  out  1  one-cycle pulse when a sequence finishes normally.
- o_bist_pass / o_bist_fail  out  1 each  final verdict; held until the next start.
- o_owt_fail / o_scan_fail / o_wdg_fail / o_bist_aborted  out  1 each  sticky detail flags for the last sequence.
- o_bist_src_por  out  1  last start came from POR.
- o_retry_cnt  out  3  retries consumed.
- i_lbist_scan_req  in  1  scan request from the BIST checker.
- o_lbist_scan_ack  out  1  ack to the BIST checker.
- i_func_scan_req  in  1  functional scan request.
- o_func_scan_ack  out  1  ack to the functional requester.
- o_scan_req  out  1  request to the scan-register engine.
- o_scan_sel  out  1  engine owner: 1 = BIST, 0 = functional.
- i_scan_ack  in  1  engine ack.

## Operation
The sequencer FSM has states IDLE, RUN, EVAL, GAP and DONE.

- **IDLE**
  - o_bist_en = 0.
  - A POR or software request goes to RUN. Entering RUN clears every result flag and o_retry_cnt, and sets o_bist_src_por = i_por_bist_req.
  - If both requests arrive together, only one sequence starts and POR wins the source flag.
- **RUN**
  - o_bist_en = 1 and the watchdog counter increments.
  - i_hv_bist_done = 1 goes to EVAL and captures the OWT and scan flags into internal attempt flags, sampled in that same cycle.
  - Watchdog = BIST_WDG_TH-1 without done goes to DONE with o_wdg_fail = 1 and o_bist_fail = 1.
- **EVAL** (one cycle, o_bist_en = 0)
  - Both attempt flags 0 goes to DONE with pass.
  - Otherwise, if o_retry_cnt < BIST_RETRY_NUM, go to GAP and increment o_retry_cnt.
  - Otherwise go to DONE with fail; the final o_owt_fail / o_scan_fail equal the last attempt's flags.
- **GAP**
  - o_bist_en = 0 for BIST_GAP_TH cycles, then back to RUN. The watchdog is cleared on every RUN entry.
  - Holding the enable low is what resets the checker's internal counters between attempts.
- **DONE**
  - o_bist_cmplt = 1 for one cycle, then IDLE.
- **Abort**
  - i_bist_abort high in any state other than IDLE goes to IDLE on the next edge. o_bist_aborted = 1, pass = fail = 0, no cmplt pulse.
  - While i_bist_abort is high, start requests are ignored.
- **Requests while busy** are dropped; they are not queued.

Scan arbiter, with lock register lock_vld and owner lock_own:
- **Owner selection** (when !lock_vld):
  - o_bist_en & i_lbist_scan_req locks BIST.
  - !o_bist_en & i_func_scan_req locks functional.
  - A functional request while o_bist_en = 1 waits.
- **Request and ack routing:**
  - o_scan_req = lock_vld & (lock_own ? i_lbist_scan_req : i_func_scan_req).
  - o_scan_sel = lock_own.
  - i_scan_ack is routed only to the locked owner; it clears lock_vld on the next edge.
- **Cancelled transaction:** if the owner's request drops while locked and no ack has arrived, the lock is released. This covers a BIST abort mid-transaction.
- **Stray ack:** an ack with !lock_vld is discarded.

## Timing
- Reset values of all outputs are 0; state = IDLE, lock_vld = 0.
- Request at edge N gives o_bist_en = 1 from cycle N+1.
- Done sampled at edge M gives o_bist_en = 0 at M+1 (EVAL).
- Pass path: o_bist_cmplt at M+2 and o_bist_pass valid from M+2.
- Retry path: o_bist_en low for BIST_GAP_TH+1 cycles, counting EVAL.
- All outputs are registered except o_scan_req, o_lbist_scan_ack and o_func_scan_ack. These three are combinational from the lock register and inputs.
- Arbitration latency: request at edge K gives lock at K+1 and o_scan_req high in cycle K+1. There is a one-cycle bubble after each ack.

## Structure
- Shared package hv_bist_pkg holds:
  - typedef enum bist_st_e {IDLE, RUN, EVAL, GAP, DONE};
  - WDG_CNT_W = $clog2(BIST_WDG_TH);
  - GAP_CNT_W = $clog2(BIST_GAP_TH+1).
- One sub-module is natural: hv_scan_arb, holding the lock, owner selection and ack routing. It takes o_bist_en as its priority input. The FSM stays in hv_bist_ctrl.

## Test plan
- **POR pass:** one POR pulse, checker done at cycle 200 with both flags 0 -> o_bist_en high for cycles 1..200, cmplt at 202, pass = 1, retry_cnt = 0, src_por = 1.
- **Retry then pass:** first attempt OWT flag = 1, second attempt clean, BIST_RETRY_NUM = 2 -> enable low for 17 cycles, pass = 1, retry_cnt = 1, owt_fail = 0.
- **Exhausted retries:** scan flag = 1 on all attempts -> 3 RUN windows, fail = 1, scan_fail = 1, retry_cnt = 2.
- **Watchdog:** done never asserted -> DONE after 4096 RUN cycles, wdg_fail = 1, fail = 1.
- **Abort mid-transaction:** abort while the BIST scan transaction is locked and before any ack arrives -> o_bist_en = 0 next cycle, lock released once the checker request drops, the pending functional request is granted after that, aborted = 1, no cmplt.
- **Arbitration and simultaneous requests:**
  - Functional request held across a BIST start -> functional served only after o_bist_en falls.
  - POR and software pulses in the same cycle -> a single sequence, src_por = 1.

Source files
------------

// File: rtl/hv_bist_pkg.sv
// Shared types and sizing helpers for the HV-side BIST sequencer and scan arbiter.
package hv_bist_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    EVAL = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } bist_st_e;

  // Result flags captured from the checker when it reports done.
  typedef struct packed {
    logic owt;
    logic scan;
  } att_flags_t;

  // Counter width for a counter that must hold values up to n-1 (at least 1 bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Default thresholds and the counter widths they imply.
  localparam int BIST_WDG_TH_DFLT = 4096;
  localparam int BIST_GAP_TH_DFLT = 16;
  localparam int WDG_CNT_W        = cnt_w(BIST_WDG_TH_DFLT);
  localparam int GAP_CNT_W        = cnt_w(BIST_GAP_TH_DFLT + 1);
  localparam int RETRY_CNT_W      = 3;

endpackage

// File: rtl/hv_bist_ctrl_scan_arb.sv
// Scan-register engine arbiter: locks the engine to the BIST checker or the
// functional requester and routes the engine ack to the locked owner only.
module hv_scan_arb (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic bist_en,
  input  logic lbist_scan_req,
  input  logic func_scan_req,
  input  logic scan_ack,
  output logic lbist_scan_ack,
  output logic func_scan_ack,
  output logic scan_req,
  output logic scan_sel
);

  logic lock_vld;
  logic lock_own;   // 1 = BIST checker, 0 = functional requester
  logic owner_req;

  assign owner_req = lock_own ? lbist_scan_req : func_scan_req;

  // Lock acquisition gives BIST exclusive ownership while enabled; the lock is
  // dropped on ack or when the owner withdraws its request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_vld <= 1'b0;
      lock_own <= 1'b0;
    end else if (!lock_vld) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // regardless of the order these statements are evaluated in.
      if (bist_en && lbist_scan_req) begin
        lock_vld <= 1'b1;
        lock_own <= 1'b1;
      end else if (!bist_en && func_scan_req) begin
        lock_vld <= 1'b1;
        lock_own <= 1'b0;
      end
    end else if (scan_ack || !owner_req) begin
      lock_vld <= 1'b0;
    end
  end

  // Request forwarding and ack routing; stray acks with no lock go nowhere.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves an output
    // unassigned, which would otherwise infer a latch.
    lbist_scan_ack = 1'b0;
    func_scan_ack  = 1'b0;
    scan_req       = lock_vld & owner_req;
    if (lock_vld) begin
      lbist_scan_ack = lock_own & scan_ack;
      func_scan_ack  = ~lock_own & scan_ack;
    end
  end

  assign scan_sel = lock_own;

endmodule

// File: rtl/hv_bist_ctrl.sv
// HV BIST sequencer: starts a logic-BIST run on POR/software request, retries
// failed attempts with an enable-low gap, guards each attempt with a watchdog,
// and reports a held pass/fail verdict. Scan arbitration lives in hv_scan_arb.
module hv_bist_ctrl
  import hv_bist_pkg::*;
#(
  parameter int BIST_RETRY_NUM = 2,
  parameter int BIST_GAP_TH    = 16,
  parameter int BIST_WDG_TH    = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_por_bist_req,
  input  logic       i_sw_bist_req,
  input  logic       i_bist_abort,
  output logic       o_bist_en,
  input  logic       i_hv_bist_done,
  input  logic       i_hv_owt_bist_rult,
  input  logic       i_hv_scan_bist_rult,
  output logic       o_bist_busy,
  output logic       o_bist_cmplt,
  output logic       o_bist_pass,
  output logic       o_bist_fail,
  output logic       o_owt_fail,
  output logic       o_scan_fail,
  output logic       o_wdg_fail,
  output logic       o_bist_aborted,
  output logic       o_bist_src_por,
  output logic [2:0] o_retry_cnt,
  input  logic       i_lbist_scan_req,
  output logic       o_lbist_scan_ack,
  input  logic       i_func_scan_req,
  output logic       o_func_scan_ack,
  output logic       o_scan_req,
  output logic       o_scan_sel,
  input  logic       i_scan_ack
);

  localparam int WDG_W = cnt_w(BIST_WDG_TH);
  localparam int GAP_W = cnt_w(BIST_GAP_TH + 1);

  localparam logic [WDG_W-1:0]       WDG_LAST  = WDG_W'(BIST_WDG_TH - 1);
  localparam logic [GAP_W-1:0]       GAP_LAST  = GAP_W'(BIST_GAP_TH - 1);
  localparam logic [RETRY_CNT_W-1:0] RETRY_MAX = RETRY_CNT_W'(BIST_RETRY_NUM);

  bist_st_e         state;
  logic [WDG_W-1:0] wdg_cnt;
  logic [GAP_W-1:0] gap_cnt;
  att_flags_t       att;
  logic             start;

  // Simultaneous POR and software requests start one sequence; abort blocks both.
  assign start = (i_por_bist_req | i_sw_bist_req) & ~i_bist_abort;

  // Sequencer with all status outputs registered alongside the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      wdg_cnt        <= '0;
      gap_cnt        <= '0;
      att            <= '0;
      o_bist_en      <= 1'b0;
      o_bist_busy    <= 1'b0;
      o_bist_cmplt   <= 1'b0;
      o_bist_pass    <= 1'b0;
      o_bist_fail    <= 1'b0;
      o_owt_fail     <= 1'b0;
      o_scan_fail    <= 1'b0;
      o_wdg_fail     <= 1'b0;
      o_bist_aborted <= 1'b0;
      o_bist_src_por <= 1'b0;
      o_retry_cnt    <= '0;
    end else begin
      o_bist_cmplt <= 1'b0;
      if (state != IDLE && i_bist_abort) begin
        // Abort exits without a verdict and without the completion pulse.
        state          <= IDLE;
        o_bist_en      <= 1'b0;
        o_bist_busy    <= 1'b0;
        o_bist_pass    <= 1'b0;
        o_bist_fail    <= 1'b0;
        o_bist_aborted <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state          <= RUN;
              o_bist_en      <= 1'b1;
              o_bist_busy    <= 1'b1;
              wdg_cnt        <= '0;
              o_bist_pass    <= 1'b0;
              o_bist_fail    <= 1'b0;
              o_owt_fail     <= 1'b0;
              o_scan_fail    <= 1'b0;
              o_wdg_fail     <= 1'b0;
              o_bist_aborted <= 1'b0;
              o_retry_cnt    <= '0;
              o_bist_src_por <= i_por_bist_req;
            end
          end
          RUN: begin
            if (i_hv_bist_done) begin
              state     <= EVAL;
              o_bist_en <= 1'b0;
              att       <= '{owt: i_hv_owt_bist_rult, scan: i_hv_scan_bist_rult};
            end else if (wdg_cnt == WDG_LAST) begin
              state        <= DONE;
              o_bist_en    <= 1'b0;
              o_wdg_fail   <= 1'b1;
              o_bist_fail  <= 1'b1;
              o_bist_cmplt <= 1'b1;
            end else begin
              wdg_cnt <= wdg_cnt + 1'b1;
            end
          end
          EVAL: begin
            if (!att.owt && !att.scan) begin
              state        <= DONE;
              o_bist_pass  <= 1'b1;
              o_bist_cmplt <= 1'b1;
            end else if (o_retry_cnt < RETRY_MAX) begin
              state       <= GAP;
              gap_cnt     <= '0;
              o_retry_cnt <= o_retry_cnt + 1'b1;
            end else begin
              state        <= DONE;
              o_bist_fail  <= 1'b1;
              o_owt_fail   <= att.owt;
              o_scan_fail  <= att.scan;
              o_bist_cmplt <= 1'b1;
            end
          end
          GAP: begin
            // Enable held low here lets the checker clear its internal counters.
            if (gap_cnt == GAP_LAST) begin
              state     <= RUN;
              o_bist_en <= 1'b1;
              wdg_cnt   <= '0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          DONE: begin
            state       <= IDLE;
            o_bist_busy <= 1'b0;
          end
          default: begin
            state       <= IDLE;
            o_bist_en   <= 1'b0;
            o_bist_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  hv_scan_arb u_scan_arb (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .bist_en        (o_bist_en),
    .lbist_scan_req (i_lbist_scan_req),
    .func_scan_req  (i_func_scan_req),
    .scan_ack       (i_scan_ack),
    .lbist_scan_ack (o_lbist_scan_ack),
    .func_scan_ack  (o_func_scan_ack),
    .scan_req       (o_scan_req),
    .scan_sel       (o_scan_sel)
  );

endmodule
